// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-client RAM arbiter.
package ram_arb_pkg;

   localparam int NUM_REQ = 2;

   typedef logic [0:0] arb_state_t;
   localparam arb_state_t ARB_IDLE  = 1'b0;
   localparam arb_state_t ARB_GRANT = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational 2-way picker. A lone requester always wins; on a tie, ptr wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       win,
   output logic       any_req
);

   assign any_req = |req;
   assign win     = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two clients.
// Optional RAM_ARB_LOCK_EN adds lock[1:0] so a client can hold priority.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*WIDTH-1:0]  wdata,
`ifdef RAM_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        lock,
`endif
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [NUM_REQ*WIDTH-1:0]  rdata,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [WIDTH-1:0]          ram_in,
   output logic                      ram_load,
   input  logic [WIDTH-1:0]          ram_out
);

   arb_state_t        state;
   logic              rr_ptr;
   logic              win_lat;
   logic              we_lat;
   logic [ADDR_W-1:0] addr_lat;
   logic [WIDTH-1:0]  wdata_lat;

   logic              win;
   logic              any_req;
   logic              pick_ptr;
   logic [ADDR_W-1:0] addr_w;
   logic [WIDTH-1:0]  wdata_w;

`ifdef RAM_ARB_LOCK_EN
   logic              lock_vld;
   logic              lock_own;
   // A valid lock owner takes the tie-break slot instead of the rotating pointer.
   assign pick_ptr = lock_vld ? lock_own : rr_ptr;
`else
   assign pick_ptr = rr_ptr;
`endif

   rr_pick2 u_pick (
      .req     (req),
      .ptr     (pick_ptr),
      .win     (win),
      .any_req (any_req)
   );

   assign addr_w  = win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
   assign wdata_w = win ? wdata[2*WIDTH-1:WIDTH]  : wdata[WIDTH-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ARB_IDLE;
         rr_ptr    <= 1'b0;
         win_lat   <= 1'b0;
         we_lat    <= 1'b0;
         addr_lat  <= '0;
         wdata_lat <= '0;
         rvalid    <= '0;
         rdata     <= '0;
`ifdef RAM_ARB_LOCK_EN
         lock_vld  <= 1'b0;
         lock_own  <= 1'b0;
`endif
      end else begin
         rvalid <= '0;
         case (state)
            ARB_IDLE: begin
`ifdef RAM_ARB_LOCK_EN
               if (lock_vld && !req[lock_own])
                  lock_vld <= 1'b0;
`endif
               if (any_req) begin
                  state     <= ARB_GRANT;
                  win_lat   <= win;
                  we_lat    <= we[win];
                  addr_lat  <= addr_w;
                  wdata_lat <= wdata_w;
`ifdef RAM_ARB_LOCK_EN
                  if (lock[win]) begin
                     lock_vld <= 1'b1;
                     lock_own <= win;
                  end else begin
                     rr_ptr <= ~win;
                     if (lock_vld && lock_own == win)
                        lock_vld <= 1'b0;
                  end
`else
                  rr_ptr <= ~win;
`endif
               end
            end
            default: begin
               state <= ARB_IDLE;
               if (!we_lat) begin
                  if (win_lat) rdata[2*WIDTH-1:WIDTH] <= ram_out;
                  else         rdata[WIDTH-1:0]       <= ram_out;
                  rvalid[win_lat] <= 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      gnt = '0;
      if (state == ARB_GRANT) gnt[win_lat] = 1'b1;
   end

   // Masking with reset keeps a write from landing in the cycle it is aborted.
   assign ram_load = (state == ARB_GRANT) & we_lat & ~reset;
   assign ram_addr = addr_lat;
   assign ram_in   = wdata_lat;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 8x16 RAM; lock cases need RAM_ARB_LOCK_EN.
module tb_ram_arbiter;

   localparam int WIDTH  = 16;
   localparam int ADDR_W = 3;

   logic                clock = 1'b0;
   logic                reset;
   logic [1:0]          req;
   logic [1:0]          we;
   logic [2*ADDR_W-1:0] addr;
   logic [2*WIDTH-1:0]  wdata;
   logic [1:0]          lock;
   logic [1:0]          gnt;
   logic [1:0]          rvalid;
   logic [2*WIDTH-1:0]  rdata;
   logic [ADDR_W-1:0]   ram_addr;
   logic [WIDTH-1:0]    ram_in;
   logic                ram_load;
   logic [WIDTH-1:0]    ram_out;

   logic [WIDTH-1:0]    mem [8];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   always @(posedge clock) if (ram_load) mem[ram_addr] <= ram_in;
   assign ram_out = mem[ram_addr];

   ram_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
`ifdef RAM_ARB_LOCK_EN
      .lock     (lock),
`endif
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .ram_addr (ram_addr),
      .ram_in   (ram_in),
      .ram_load (ram_load),
      .ram_out  (ram_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [1:0] exp_g [8];
   logic [1:0] exp_v [8];

   initial begin
      exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      exp_v = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
      reset = 1'b1;
      req   = 2'b11;
      we    = 2'b00;
      addr  = '0;
      wdata = '0;
      lock  = 2'b00;

      // reset held two cycles with both clients requesting
      tick();
      tick();
      chk("rst_gnt",    32'(gnt),      32'h0);
      chk("rst_rvalid", 32'(rvalid),   32'h0);
      chk("rst_rdata",  rdata,         32'h0);
      chk("rst_load",   32'(ram_load), 32'h0);

      // first grant after release goes to client 0 (read addr 0)
      reset = 1'b0;
      tick();
      chk("first_gnt", 32'(gnt), 32'h1);
      req = 2'b00;
      tick();
      chk("first_rvalid", 32'(rvalid), 32'h1);
      chk("first_rdata",  rdata,       32'h0000_1000);

      // client 0 writes BEEF to addr 3
      req   = 2'b01;
      we    = 2'b01;
      addr  = {3'd0, 3'd3};
      wdata = {16'h0, 16'hBEEF};
      tick();
      chk("wr_gnt",    32'(gnt),      32'h1);
      chk("wr_load",   32'(ram_load), 32'h1);
      chk("wr_addr",   32'(ram_addr), 32'h3);
      chk("wr_in",     32'(ram_in),   32'hBEEF);
      chk("wr_rvalid", 32'(rvalid),   32'h0);
      req = 2'b00;
      we  = 2'b00;
      tick();
      chk("wr_rvalid2", 32'(rvalid), 32'h0);
      chk("wr_mem3",    32'(mem[3]), 32'hBEEF);
      chk("idle_load",  32'(ram_load), 32'h0);
      chk("idle_addr",  32'(ram_addr), 32'h3);

      // client 1 reads back addr 3
      req  = 2'b10;
      addr = {3'd3, 3'd0};
      tick();
      chk("rd1_gnt", 32'(gnt), 32'h2);
      req = 2'b00;
      tick();
      chk("rd1_rvalid", 32'(rvalid), 32'h2);
      chk("rd1_rdata",  rdata,       32'hBEEF_1000);

      // both clients hold req: grants alternate at 2-cycle spacing
      req  = 2'b11;
      addr = {3'd2, 3'd1};
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("alt_gnt%0d", i),    32'(gnt),    32'(exp_g[i]));
         chk($sformatf("alt_rvalid%0d", i), 32'(rvalid), 32'(exp_v[i]));
      end
      chk("alt_rdata", rdata, 32'h1002_1001);
      req = 2'b00;
      tick();

      // reset lands in the GRANT cycle of a write to addr 5
      req   = 2'b01;
      we    = 2'b01;
      addr  = {3'd0, 3'd5};
      wdata = {16'h0, 16'h1234};
      tick();
      chk("rg_gnt", 32'(gnt), 32'h1);
      reset = 1'b1;
      req   = 2'b00;
      #1;
      chk("rg_load", 32'(ram_load), 32'h0);
      tick();
      reset = 1'b0;
      we    = 2'b00;
      chk("rg_mem5",   32'(mem[5]), 32'h1005);
      chk("rg_gnt2",   32'(gnt),    32'h0);
      chk("rg_rvalid", 32'(rvalid), 32'h0);
      chk("rg_rdata",  rdata,       32'h0);

`ifdef RAM_ARB_LOCK_EN
      // client 0 locks and wins three in a row, then releases
      req  = 2'b11;
      lock = 2'b01;
      addr = {3'd2, 3'd1};
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("lk_gnt%0d", i), 32'(gnt), 32'h1);
         if (i == 2) begin
            req  = 2'b10;
            lock = 2'b00;
         end
         tick();
         chk($sformatf("lk_gap%0d", i), 32'(gnt), 32'h0);
      end
      tick();
      chk("lk_release_gnt", 32'(gnt), 32'h2);
      req = 2'b00;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester round-robin arbiter that shares one single-port RAM (combinational read, write on clock edge) between two clients. It arbitrates, latches the winner's command and drives the RAM interface for one grant cycle. It returns read data with a one-cycle-pulsed valid. It sits between two independent datapath clients and a shared RAM8/RAM64-style store.

Parameters:
WIDTH, 16, data word width
ADDR_W, 3, RAM address width

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req  in  2  req[i]: client i requests an access; held high until gnt[i] seen
we  in  2  we[i]: 1 = write, 0 = read; stable while req[i] high
addr  in  2*ADDR_W  client i address in bits [i*ADDR_W +: ADDR_W]
wdata  in  2*WIDTH  client i write data in bits [i*WIDTH +: WIDTH]
gnt  out  2  one-cycle grant pulse; one-hot or zero
rvalid  out  2  one-cycle read-data-valid pulse
rdata  out  2*WIDTH  client i read data, held until next read by i
ram_addr  out  ADDR_W  RAM address
ram_in  out  WIDTH  RAM write data
ram_load  out  1  RAM write enable
ram_out  in  WIDTH  RAM combinational read data

Behaviour:
- Reset: state=IDLE, rr_ptr=0, gnt=0, rvalid=0, rdata=0, latched command=0, ram_load=0. Reset in the same cycle as req is ignored.
- FSM states: IDLE and GRANT.
- IDLE with any req bit set: pick winner w, latch addr/we/wdata of w, go to GRANT. No req: stay in IDLE.
- GRANT always returns to IDLE. GRANT never arbitrates; req sampled during GRANT is ignored. Maximum rate is one access per 2 cycles.
- Pick rule: single requester wins regardless of pointer. Both requesting: rr_ptr wins. After each grant, rr_ptr = ~w.
- Timing: req sampled at edge ending cycle T. gnt[w]=1 during T+1 (GRANT). ram_addr/ram_in driven from latched values during T+1. ram_load = latched we during T+1.
- Client contract: client deasserts req on the edge where it samples gnt=1. A req still high at T+2 is a new request.
- Read: rdata[w] <= ram_out at the edge ending T+1. rvalid[w]=1 during T+2 only. Other client's rdata unchanged.
- Write: RAM captures at the edge ending T+1. rvalid is not asserted for writes.
- ram_addr/ram_in hold last latched values in IDLE. ram_load=0 outside GRANT.
- Reset mid-GRANT: ram_load = (state==GRANT) & we_lat & ~reset, so no write lands in a reset cycle. rvalid is not produced.
- Read-after-write across clients returns new data (serialised by grant order).
- gnt never has both bits set.

Optional Feature:
RAM_ARB_LOCK_EN
- Defined: adds input lock[1:0] and internal lock_owner state.
- If winner w has lock[w]=1 at its arbitration edge, rr_ptr is not rotated and lock_owner=w.
- While lock_owner valid, an IDLE req from the owner beats the other client.
- Lock clears when the owner is granted with lock=0, or when an IDLE cycle sees the owner's req=0.
- Reset clears the lock.
- Undefined: no lock port; pure round-robin as above.

Decomposition:
- Package ram_arb_pkg: state typedef (ARB_IDLE, ARB_GRANT) and constant NUM_REQ=2.
- Sub-module rr_pick2: combinational 2-way picker; inputs req[1:0] and ptr, outputs winner index and any_req.
- FSM, command latch and read-data capture stay in ram_arbiter.

Test Plan:
- Reset held 2 cycles with req=2'b11 -> gnt=0, rvalid=0, rdata=0, ram_load=0; after release, first grant goes to client 0.
- Client 0 writes addr 3, data 16'hBEEF, req0 at T -> gnt=2'b01, ram_load=1, ram_addr=3, ram_in=16'hBEEF in T+1; rvalid stays 0; RAM model holds BEEF.
- Client 1 reads addr 3 after that write -> gnt=2'b10 in T+1; rvalid=2'b10 in T+2; rdata[31:16]=16'hBEEF; rdata[15:0] unchanged.
- Both clients hold req continuously (reads of addrs 1 and 2) -> grants alternate 01,10,01,10 at 2-cycle spacing; never both bits set.
- Reset asserted during GRANT of client 0 write to addr 5 (data 16'h1234) -> ram_load=0 that cycle; RAM addr 5 unchanged; next cycle gnt=0, state IDLE.
- RAM_ARB_LOCK_EN: client 0 lock=1 and both requesting -> client 0 wins 3 consecutive grants; client 0 drops lock -> next grant goes to client 1.
